// File: rtl/control_carros.sv
// control_carros: sequencer for the obstacle-car slots (spawn, advance, retire), score and game state
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   inicio, pausa       start/restart and pause requests (levels)
//   choque, tick_frame  collision flag, one-cycle pulse per video frame
//   posicion_y_bus      current Y of every car, slot k in bits [9k+8:9k]
//   enable, suma, salto per-slot load, Y+1 and jump-to-park strobes
//   posicion_x/_y       shared spawn coordinates (Y fixed at 0)
//   posicion_aux_x/_y   parking coordinates loaded by salto
//   puntaje, estado     saturating score; 0 idle, 1 playing, 2 paused, 3 game over
module control_carros #(
  parameter int NUM_CARROS    = 3,
  parameter int PERIODO_SPAWN = 64,
  parameter int PASOS         = 2,
  parameter int Y_LIMITE      = 440,
  parameter int X_MIN         = 160,
  parameter int PARK_X        = 0,
  parameter int PARK_Y        = 480
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inicio,
  input  logic                    pausa,
  input  logic                    choque,
  input  logic                    tick_frame,
  input  logic [9*NUM_CARROS-1:0] posicion_y_bus,
  output logic [NUM_CARROS-1:0]   enable,
  output logic [NUM_CARROS-1:0]   suma,
  output logic [NUM_CARROS-1:0]   salto,
  output logic [9:0]              posicion_x,
  output logic [8:0]              posicion_y,
  output logic [9:0]              posicion_aux_x,
  output logic [8:0]              posicion_aux_y,
  output logic [7:0]              puntaje,
  output logic [1:0]              estado
);
  typedef enum logic [1:0] {IDLE = 2'd0, JUEGO = 2'd1, PAUSA = 2'd2, FIN = 2'd3} estado_t;
  typedef enum logic [1:0] {ESPERA, MOVER, REVISAR, RETIRAR} fase_t;
  localparam int CW = $clog2(PERIODO_SPAWN);
  localparam logic [CW-1:0] CNT_MAX = CW'(PERIODO_SPAWN - 1);
  localparam logic [CW-1:0] CNT_UNO = CW'(1);
  localparam logic [2:0] PASOS_L = 3'(PASOS);
  localparam logic [8:0] Y_LIM = 9'(Y_LIMITE);
  localparam logic [9:0] X_BASE = 10'(X_MIN);
  localparam logic [NUM_CARROS-1:0] UNO = NUM_CARROS'(1);
  estado_t st, st_n;
  fase_t fase, fase_n;
  logic [NUM_CARROS-1:0] activo, activo_n, enable_n, suma_n, salto_n, libre, fuera;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] paso, paso_n;
  logic [7:0] lfsr, lfsr_n, puntaje_n;
  logic [9:0] posicion_x_n;
  logic [3:0] n_fuera;
  logic [8:0] suma_puntos;
  assign posicion_y = '0;
  assign posicion_aux_x = 10'(PARK_X);
  assign posicion_aux_y = 9'(PARK_Y);
  assign estado = st;
  // adding one carries through the trailing active slots, isolating the lowest free one
  assign libre = ~activo & (activo + UNO);
  assign lfsr_n = tick_frame ? {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]} : lfsr;
  assign suma_puntos = {1'b0, puntaje} + {5'b0, n_fuera};
  always_comb begin
    fuera = '0;
    n_fuera = '0;
    for (int k = 0; k < NUM_CARROS; k++) begin
      fuera[k] = activo[k] && (posicion_y_bus[9*k +: 9] >= Y_LIM);
      n_fuera = n_fuera + 4'(fuera[k]);
    end
  end
  always_comb begin
    st_n = st;
    fase_n = fase;
    activo_n = activo;
    cnt_n = cnt;
    paso_n = paso;
    enable_n = '0;
    suma_n = '0;
    salto_n = '0;
    posicion_x_n = posicion_x;
    puntaje_n = puntaje;
    if ((st == JUEGO || st == PAUSA) && choque)
      st_n = FIN;
    else if ((st == IDLE || st == FIN) && inicio) begin
      st_n = JUEGO;
      fase_n = ESPERA;
      salto_n = '1;
      activo_n = '0;
      puntaje_n = '0;
      cnt_n = '0;
    end else if (st == PAUSA) begin
      st_n = pausa ? PAUSA : JUEGO;
      fase_n = ESPERA;
    end else if (st == JUEGO)
      case (fase)
        ESPERA:
          if (pausa)
            st_n = PAUSA;
          else if (tick_frame) begin
            fase_n = MOVER;
            paso_n = 3'd1;
            suma_n = activo;
            cnt_n = (cnt == CNT_MAX) ? '0 : cnt + CNT_UNO;
            if (cnt == CNT_MAX && libre != '0) begin
              enable_n = libre;
              activo_n = activo | libre;
              posicion_x_n = X_BASE + {2'b0, lfsr};
            end
          end
        MOVER: begin
          suma_n = (paso == PASOS_L) ? '0 : suma;
          fase_n = (paso == PASOS_L) ? REVISAR : MOVER;
          paso_n = paso + 3'd1;
        end
        REVISAR: begin
          salto_n = fuera;
          activo_n = activo & ~fuera;
          puntaje_n = suma_puntos[8] ? 8'hFF : suma_puntos[7:0];
          fase_n = RETIRAR;
        end
        default: fase_n = ESPERA;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      st <= IDLE;
      fase <= ESPERA;
      activo <= '0;
      cnt <= '0;
      paso <= '0;
      lfsr <= 8'hA5;
      enable <= '0;
      suma <= '0;
      salto <= '0;
      posicion_x <= X_BASE;
      puntaje <= '0;
    end else begin
      st <= st_n;
      fase <= fase_n;
      activo <= activo_n;
      cnt <= cnt_n;
      paso <= paso_n;
      lfsr <= lfsr_n;
      enable <= enable_n;
      suma <= suma_n;
      salto <= salto_n;
      posicion_x <= posicion_x_n;
      puntaje <= puntaje_n;
    end
endmodule

// File: tb/tb_control_carros.sv
// tb_control_carros: directed scenarios plus random play of control_carros against a cycle-scheduled model
module tb_control_carros;
  localparam int NC = 3;
  localparam int PER = 2;
  localparam int PAS = 2;
  localparam int YLIM = 10;
  localparam int XMIN = 160;
  logic clk = 0;
  logic rst = 1, inicio = 0, pausa = 0, choque = 0, tick_frame = 0;
  logic congelar = 0;
  logic [9*NC-1:0] posicion_y_bus;
  logic [NC-1:0] enable, suma, salto;
  logic [9:0] posicion_x, posicion_aux_x;
  logic [8:0] posicion_y, posicion_aux_y;
  logic [7:0] puntaje;
  logic [1:0] estado;
  logic [8:0] car_y [NC] = '{default: 9'd480};
  int n_cmp = 0, n_bad = 0;
  control_carros #(.NUM_CARROS(NC), .PERIODO_SPAWN(PER), .PASOS(PAS), .Y_LIMITE(YLIM)) dut (
    .clk(clk), .rst(rst), .inicio(inicio), .pausa(pausa), .choque(choque),
    .tick_frame(tick_frame), .posicion_y_bus(posicion_y_bus),
    .enable(enable), .suma(suma), .salto(salto),
    .posicion_x(posicion_x), .posicion_y(posicion_y),
    .posicion_aux_x(posicion_aux_x), .posicion_aux_y(posicion_aux_y),
    .puntaje(puntaje), .estado(estado)
  );
  always #5 clk = ~clk;
  assign posicion_y_bus = {car_y[2], car_y[1], car_y[0]};
  // car position registers driven by the DUT strobes; congelar stalls advancing to fill every slot
  always @(posedge clk)
    for (int k = 0; k < NC; k++)
      if (enable[k]) car_y[k] <= 9'd0;
      else if (salto[k]) car_y[k] <= 9'd480;
      else if (suma[k] && !congelar) car_y[k] <= car_y[k] + 9'd1;
  // reference: game state plus a burst scheduled by absolute cycle number of its accepted tick
  int cyc = 0, mst = 0, tb0 = 0, cnt = 0, px = XMIN, pts = 0;
  bit burst = 0, armed = 0;
  logic [NC-1:0] mask = '0, spawn = '0, act = '0, ret, e_en = '0, e_su = '0, e_sa = '0;
  logic [7:0] lfsr = 8'hA5;
  always @(posedge clk) begin
    e_en = '0;
    e_su = '0;
    e_sa = '0;
    if (rst) begin
      mst = 0; burst = 0; act = '0; cnt = 0; lfsr = 8'hA5; px = XMIN; pts = 0; armed = 1;
    end else begin
      if ((mst == 1 || mst == 2) && choque) begin
        mst = 3; burst = 0;
      end else if ((mst == 0 || mst == 3) && inicio) begin
        mst = 1; e_sa = '1; act = '0; pts = 0; cnt = 0; burst = 0;
      end else if (mst == 2) begin
        if (!pausa) mst = 1;
      end else if (mst == 1 && !burst) begin
        if (pausa) mst = 2;
        else if (tick_frame) begin
          burst = 1; tb0 = cyc; mask = act; spawn = '0;
          cnt = (cnt + 1) % PER;
          if (cnt == 0)
            for (int k = NC - 1; k >= 0; k--)
              if (!act[k]) spawn = NC'(1 << k);
          if (spawn != '0) begin
            act = act | spawn;
            px = XMIN + int'(lfsr);
          end
        end
      end else if (mst == 1) begin
        if (cyc == tb0 + PAS + 1) begin
          ret = '0;
          for (int k = 0; k < NC; k++) ret[k] = act[k] && (int'(car_y[k]) >= YLIM);
          act = act & ~ret;
          pts = pts + $countones(ret);
          if (pts > 255) pts = 255;
          e_sa = ret;
        end
        if (cyc == tb0 + PAS + 2) burst = 0;
      end
      if (tick_frame) lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (burst && cyc + 1 == tb0 + 1) e_en = spawn;
      if (burst && cyc + 1 >= tb0 + 1 && cyc + 1 <= tb0 + PAS) e_su = mask;
    end
    cyc++;
  end
  task automatic chk(input string nombre, input logic [9:0] got, input logic [9:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nombre, $time, got, exp);
    end
  endtask
  always @(negedge clk)
    if (armed) begin
      chk("enable", 10'(enable), 10'(e_en));
      chk("suma", 10'(suma), 10'(e_su));
      chk("salto", 10'(salto), 10'(e_sa));
      chk("posicion_x", posicion_x, 10'(px));
      chk("puntaje", 10'(puntaje), 10'(pts));
      chk("estado", 10'(estado), 10'(mst));
      chk("posicion_y", 10'(posicion_y), 10'd0);
      chk("aux_x", posicion_aux_x, 10'd0);
      chk("aux_y", 10'(posicion_aux_y), 10'd480);
      chk("one_strobe", 10'((enable & suma) | (enable & salto) | (suma & salto)), 10'd0);
    end
  task automatic frame_w();
    tick_frame = 1;
    @(negedge clk);
    tick_frame = 0;
    repeat (4) @(negedge clk);
  endtask
  initial begin
    int gap;
    repeat (3) @(negedge clk);
    chk("lit_rst_estado", 10'(estado), 10'd0);
    chk("lit_rst_px", posicion_x, 10'd160);
    chk("lit_rst_strobes", 10'({enable, suma, salto}), 10'd0);
    rst = 0;
    @(negedge clk);
    inicio = 1;
    @(negedge clk);
    inicio = 0;
    chk("lit_ini_salto", 10'(salto), 10'b111);
    chk("lit_ini_estado", 10'(estado), 10'd1);
    @(negedge clk);
    chk("lit_ini_salto_1c", 10'(salto), 10'd0);
    frame_w();
    tick_frame = 1;
    @(negedge clk);
    tick_frame = 0;
    chk("lit_spawn_en", 10'(enable), 10'b001);
    chk("lit_spawn_px", posicion_x, 10'd234);
    chk("lit_spawn_suma", 10'(suma), 10'd0);
    repeat (4) @(negedge clk);
    tick_frame = 1;
    @(negedge clk);
    tick_frame = 0;
    chk("lit_suma_c1", 10'(suma), 10'b001);
    @(negedge clk);
    chk("lit_suma_c2", 10'(suma), 10'b001);
    @(negedge clk);
    chk("lit_suma_c3", 10'(suma), 10'd0);
    repeat (2) @(negedge clk);
    repeat (3) frame_w();
    tick_frame = 1;
    @(negedge clk);
    tick_frame = 0;
    repeat (3) @(negedge clk);
    chk("lit_retire_salto", 10'(salto), 10'b001);
    chk("lit_retire_pts", 10'(puntaje), 10'd1);
    @(negedge clk);
    tick_frame = 1;
    @(negedge clk);
    tick_frame = 0;
    chk("lit_reuse_en", 10'(enable), 10'b001);
    repeat (4) @(negedge clk);
    congelar = 1;
    frame_w();
    tick_frame = 1;
    @(negedge clk);
    tick_frame = 0;
    chk("lit_full_en", 10'(enable), 10'd0);
    chk("lit_full_suma", 10'(suma), 10'b111);
    repeat (4) @(negedge clk);
    congelar = 0;
    tick_frame = 1;
    @(negedge clk);
    tick_frame = 0;
    choque = 1;
    @(negedge clk);
    choque = 0;
    chk("lit_choque_suma", 10'(suma), 10'd0);
    chk("lit_choque_estado", 10'(estado), 10'd3);
    chk("lit_choque_pts", 10'(puntaje), 10'd1);
    repeat (2) @(negedge clk);
    inicio = 1;
    @(negedge clk);
    inicio = 0;
    chk("lit_rest_salto", 10'(salto), 10'b111);
    chk("lit_rest_pts", 10'(puntaje), 10'd0);
    chk("lit_rest_estado", 10'(estado), 10'd1);
    @(negedge clk);
    pausa = 1;
    @(negedge clk);
    chk("lit_pausa_estado", 10'(estado), 10'd2);
    tick_frame = 1;
    @(negedge clk);
    tick_frame = 0;
    chk("lit_pausa_strobes", 10'({enable, suma, salto}), 10'd0);
    repeat (4) @(negedge clk);
    pausa = 0;
    @(negedge clk);
    chk("lit_reanuda_estado", 10'(estado), 10'd1);
    frame_w();
    frame_w();
    tick_frame = 1;
    @(negedge clk);
    tick_frame = 0;
    chk("lit_mover_suma", 10'(suma), 10'b001);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("lit_rst_mid_strobes", 10'({enable, suma, salto}), 10'd0);
    chk("lit_rst_mid_estado", 10'(estado), 10'd0);
    gap = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      gap++;
      tick_frame = 0;
      if (gap >= 5 && $urandom_range(2) == 0) begin
        tick_frame = 1;
        gap = 0;
      end
      inicio = ($urandom_range(15) == 0);
      choque = ($urandom_range(150) == 0);
      rst = ($urandom_range(400) == 0);
      if ($urandom_range(40) == 0) pausa = ~pausa;
      if ($urandom_range(60) == 0) congelar = ~congelar;
    end
    @(negedge clk);
    {rst, tick_frame, inicio, choque, pausa, congelar} = 6'b100000;
    repeat (5) @(negedge clk);
    rst = 0;
    @(negedge clk);
    inicio = 1;
    @(negedge clk);
    inicio = 0;
    @(negedge clk);
    repeat (560) frame_w();
    chk("lit_sat_pts", 10'(puntaje), 10'd255);
    chk("lit_sat_estado", 10'(estado), 10'd1);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
